// File: rtl/posit_pkg.sv
// posit_pkg: shared definitions for the posit round/normalise stage.
//   - default datapath widths (DEF_IN_W, DEF_OUT_W, DEF_K_W, DEF_ES)
//   - rounding-mode encodings (RND_TRUNC, RND_RNE, RND_AWAY, RND_UP)
//   - FSM state encoding (S_IDLE, S_ROUND, S_NORM, S_DONE)
package posit_pkg;

  localparam int DEF_IN_W  = 64;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_K_W   = 6;
  localparam int DEF_ES    = 3;

  localparam logic [1:0] RND_TRUNC = 2'b00;
  localparam logic [1:0] RND_RNE   = 2'b01;
  localparam logic [1:0] RND_AWAY  = 2'b10;
  localparam logic [1:0] RND_UP    = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_NORM  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/posit_round_bits.sv
// posit_round_bits: combinational rounding-bit extraction and increment decision.
// Ports:
//   low_i    - low IN_W-OUT_W+1 bits of the mantissa (lsb of the kept field and below)
//   mode_i   - rounding mode
//   lsb_o    - least significant kept bit
//   guard_o  - first discarded bit
//   sticky_o - OR of all remaining discarded bits
//   inc_o    - 1 when the kept field must be incremented
module posit_round_bits
  import posit_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-OUT_W:0] low_i,
  input  logic [1:0]          mode_i,
  output logic                lsb_o,
  output logic                guard_o,
  output logic                sticky_o,
  output logic                inc_o
);

  localparam int T = IN_W - OUT_W;

  assign lsb_o    = low_i[T];
  assign guard_o  = low_i[T-1];
  assign sticky_o = |low_i[T-2:0];

  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RND_TRUNC: inc_o = 1'b0;
      RND_RNE:   inc_o = guard_o & (sticky_o | lsb_o);
      RND_AWAY:  inc_o = guard_o;
      RND_UP:    inc_o = guard_o | sticky_o;
      default:   inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/posit_round_norm.sv
// posit_round_norm: rounds a normalised IN_W-bit mantissa to OUT_W bits, propagates
// the rounding carry into exponent and regime, and saturates at maxpos.
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   start / done       - 4-phase level request / result valid
//   rnd_mode           - 00 trunc, 01 RNE, 10 ties-away, 11 magnitude-up
//   shifted_mantissa, k_out, exp_out, sign_out - operand
//   mantissa_out, k_final, exp_final, sign_final - result (held until next NORM)
// Optional macro POSIT_ROUND_FLAGS_EN adds outputs inexact and saturated.
//
// state   | meaning
// S_IDLE  | wait for start, capture operand and mode
// S_ROUND | register incremented kept field (carry in MSB)
// S_NORM  | apply carry / exponent wrap / saturation, register outputs
// S_DONE  | done=1 until start drops
module posit_round_norm
  import posit_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int K_W   = DEF_K_W,
  parameter int ES    = DEF_ES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       rnd_mode,
  input  logic [IN_W-1:0]  shifted_mantissa,
  input  logic [K_W-1:0]   k_out,
  input  logic [ES-1:0]    exp_out,
  input  logic             sign_out,
  output logic [OUT_W-1:0] mantissa_out,
  output logic [K_W-1:0]   k_final,
  output logic [ES-1:0]    exp_final,
  output logic             sign_final,
`ifdef POSIT_ROUND_FLAGS_EN
  output logic             inexact,
  output logic             saturated,
`endif
  output logic             done
);

  localparam logic [K_W-1:0] K_MAX = {1'b0, {(K_W-1){1'b1}}};

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  sm_q;
  logic [K_W-1:0]   k_q;
  logic [ES-1:0]    exp_q;
  logic             sign_q;
  logic [1:0]       mode_q;
  logic [OUT_W:0]   rnd_q, rnd_d;
  logic [OUT_W-1:0] mant_q, mant_d;
  logic [K_W-1:0]   kf_q, kf_d;
  logic [ES-1:0]    ef_q, ef_d;
  logic             sf_q;
  logic             done_q;
  logic             sat_d;
  logic             lsb, guard, sticky, inc;
  logic             unused_bits;

  posit_round_bits #(.IN_W(IN_W), .OUT_W(OUT_W)) u_bits (
    .low_i    (sm_q[IN_W-OUT_W:0]),
    .mode_i   (mode_q),
    .lsb_o    (lsb),
    .guard_o  (guard),
    .sticky_o (sticky),
    .inc_o    (inc)
  );

  assign unused_bits = lsb ^ guard ^ sticky;

  // Extra MSB catches the carry out of an all-ones kept field.
  // A zero mantissa never increments, so zero needs no special path.
  assign rnd_d = {1'b0, sm_q[IN_W-1:IN_W-OUT_W]} + {{OUT_W{1'b0}}, inc};

  always_comb begin
    mant_d = rnd_q[OUT_W-1:0];
    ef_d   = exp_q;
    kf_d   = k_q;
    sat_d  = 1'b0;
    if (rnd_q[OUT_W]) begin
      mant_d = {1'b1, {(OUT_W-1){1'b0}}};
      if (exp_q != {ES{1'b1}}) begin
        ef_d = exp_q + 1'b1;
      end else if (k_q != K_MAX) begin
        ef_d = '0;
        kf_d = k_q + 1'b1;
      end else begin
        mant_d = '1;
        ef_d   = '1;
        kf_d   = K_MAX;
        sat_d  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ROUND;
      S_ROUND: state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sm_q    <= '0;
      k_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      mode_q  <= '0;
      rnd_q   <= '0;
      mant_q  <= '0;
      kf_q    <= '0;
      ef_q    <= '0;
      sf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          sm_q   <= shifted_mantissa;
          k_q    <= k_out;
          exp_q  <= exp_out;
          sign_q <= sign_out;
          mode_q <= rnd_mode;
        end
        S_ROUND: rnd_q <= rnd_d;
        S_NORM: begin
          mant_q <= mant_d;
          kf_q   <= kf_d;
          ef_q   <= ef_d;
          sf_q   <= sign_q;
          done_q <= 1'b1;
        end
        S_DONE: if (!start) done_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef POSIT_ROUND_FLAGS_EN
  logic inex_rnd_q, inexact_q, saturated_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inex_rnd_q  <= 1'b0;
      inexact_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      if (state_q == S_ROUND) inex_rnd_q <= guard | sticky;
      if (state_q == S_NORM) begin
        inexact_q   <= inex_rnd_q;
        saturated_q <= sat_d;
      end
    end
  end

  assign inexact   = inexact_q;
  assign saturated = saturated_q;
`endif

  assign mantissa_out = mant_q;
  assign k_final      = kf_q;
  assign exp_final    = ef_q;
  assign sign_final   = sf_q;
  assign done         = done_q;

endmodule

// File: tb/tb_posit_round_norm.sv
module tb_posit_round_norm;

  typedef struct {
    logic [31:0] m;
    logic [5:0]  k;
    logic [2:0]  e;
    logic        s;
    logic        inex;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rnd_mode = '0;
  logic [63:0] shifted_mantissa = '0;
  logic [5:0]  k_out = '0;
  logic [2:0]  exp_out = '0;
  logic        sign_out = 1'b0;
  logic [31:0] mantissa_out;
  logic [5:0]  k_final;
  logic [2:0]  exp_final;
  logic        sign_final;
  logic        done;
`ifdef POSIT_ROUND_FLAGS_EN
  logic        inexact, saturated;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  posit_round_norm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .rnd_mode         (rnd_mode),
    .shifted_mantissa (shifted_mantissa),
    .k_out            (k_out),
    .exp_out          (exp_out),
    .sign_out         (sign_out),
    .mantissa_out     (mantissa_out),
    .k_final          (k_final),
    .exp_final        (exp_final),
    .sign_final       (sign_final),
`ifdef POSIT_ROUND_FLAGS_EN
    .inexact          (inexact),
    .saturated        (saturated),
`endif
    .done             (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(logic [31:0] m, logic [5:0] k, logic [2:0] e, logic s,
                              logic inex, logic sat);
    exp_t r;
    r.m = m; r.k = k; r.e = e; r.s = s; r.inex = inex; r.sat = sat;
    return r;
  endfunction

  // Reference rounding for the default 64->32, K_W=6, ES=3 configuration.
  function automatic exp_t model(logic [63:0] sm, logic [5:0] k, logic [2:0] e,
                                 logic s, logic [1:0] md);
    exp_t        r;
    logic [31:0] kept;
    logic        l, g, st, inc;
    kept = sm[63:32];
    l    = sm[32];
    g    = sm[31];
    st   = |sm[30:0];
    case (md)
      2'b00:   inc = 1'b0;
      2'b01:   inc = g & (st | l);
      2'b10:   inc = g;
      default: inc = g | st;
    endcase
    r = mk(kept, k, e, s, g | st, 1'b0);
    if (inc) begin
      if (kept == 32'hFFFF_FFFF) begin
        r.m = 32'h8000_0000;
        if (e != 3'd7) r.e = e + 3'd1;
        else if (k != 6'd31) begin
          r.e = 3'd0;
          r.k = k + 6'd1;
        end else begin
          r.m = 32'hFFFF_FFFF; r.e = 3'd7; r.k = 6'd31; r.sat = 1'b1;
        end
      end else begin
        r.m = kept + 32'd1;
      end
    end
    return r;
  endfunction

  // Edges are counted including the one that samples start; done must be
  // visible after the third.
  task automatic run_req(input logic [63:0] sm, input logic [5:0] k, input logic [2:0] e,
                         input logic s, input logic [1:0] md, input bit hold, input exp_t ex);
    exp_t want;
    int   lat;
    sb.push_back(ex);
    @(negedge clk);
    shifted_mantissa = sm; k_out = k; exp_out = e; sign_out = s; rnd_mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    shifted_mantissa = ~sm; k_out = ~k; exp_out = ~e; sign_out = ~s; rnd_mode = ~md;
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    want = sb.pop_front();
    chk("mantissa", 64'(mantissa_out), 64'(want.m));
    chk("k", 64'(k_final), 64'(want.k));
    chk("exp", 64'(exp_final), 64'(want.e));
    chk("sign", 64'(sign_final), 64'(want.s));
`ifdef POSIT_ROUND_FLAGS_EN
    chk("inexact", 64'(inexact), 64'(want.inex));
    chk("saturated", 64'(saturated), 64'(want.sat));
`endif
    if (hold) begin
      repeat (2) begin
        @(posedge clk); #1;
        chk("done_hold", 64'(done), 64'd1);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk("done_drop", 64'(done), 64'd0);
    end else begin
      @(posedge clk); #1;
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  task automatic run_model(input logic [63:0] sm, input logic [5:0] k, input logic [2:0] e,
                           input logic s, input logic [1:0] md, input bit hold);
    run_req(sm, k, e, s, md, hold, model(sm, k, e, s, md));
  endtask

  initial begin
    bit          seen;
    logic [63:0] sm;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mant", 64'(mantissa_out), 64'd0);
    chk("rst_kexp", 64'({k_final, exp_final, sign_final}), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(64'hAAAAAAAA_FFFFFFFF, 6'd5, 3'd4, 1'b0, 2'b01, 1'b1,
            mk(32'hAAAAAAAB, 6'd5, 3'd4, 1'b0, 1'b1, 1'b0));
    run_req(64'hAAAAAAAA_FFFFFFFF, 6'd5, 3'd4, 1'b1, 2'b00, 1'b0,
            mk(32'hAAAAAAAA, 6'd5, 3'd4, 1'b1, 1'b1, 1'b0));
    run_req(64'h80000001_80000000, 6'd0, 3'd1, 1'b0, 2'b01, 1'b0,
            mk(32'h80000002, 6'd0, 3'd1, 1'b0, 1'b1, 1'b0));
    run_req(64'h80000000_80000000, 6'd0, 3'd1, 1'b0, 2'b01, 1'b0,
            mk(32'h80000000, 6'd0, 3'd1, 1'b0, 1'b1, 1'b0));
    run_req(64'h80000000_80000000, 6'd0, 3'd1, 1'b0, 2'b10, 1'b1,
            mk(32'h80000001, 6'd0, 3'd1, 1'b0, 1'b1, 1'b0));
    run_req(64'hFFFFFFFF_80000000, 6'd2, 3'd3, 1'b0, 2'b01, 1'b0,
            mk(32'h80000000, 6'd2, 3'd4, 1'b0, 1'b1, 1'b0));
    run_req(64'hFFFFFFFF_80000000, 6'b111101, 3'd7, 1'b1, 2'b01, 1'b0,
            mk(32'h80000000, 6'b111110, 3'd0, 1'b1, 1'b1, 1'b0));
    run_req(64'hFFFFFFFF_80000000, 6'd31, 3'd7, 1'b0, 2'b01, 1'b0,
            mk(32'hFFFFFFFF, 6'd31, 3'd7, 1'b0, 1'b1, 1'b1));
    run_req(64'h0, 6'b111100, 3'd2, 1'b0, 2'b11, 1'b0,
            mk(32'h0, 6'b111100, 3'd2, 1'b0, 1'b0, 1'b0));
    run_req(64'hFFFFFFFF_00000001, 6'd3, 3'd5, 1'b0, 2'b11, 1'b0,
            mk(32'h80000000, 6'd3, 3'd6, 1'b0, 1'b1, 1'b0));

    // Reset while in NORM: outputs clear at once and the request is lost.
    @(negedge clk);
    shifted_mantissa = 64'hC0000000_FFFFFFFF; k_out = 6'd1; exp_out = 3'd1; rnd_mode = 2'b01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mant", 64'(mantissa_out), 64'd0);
    chk("midrst_kexp", 64'({k_final, exp_final, sign_final}), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);

    for (int i = 0; i < 24; i++) begin
      sm = {$urandom, $urandom};
      sm[63] = 1'b1;
      if ($urandom_range(0, 3) == 0) sm[63:32] = '1;
      if ($urandom_range(0, 9) == 0) sm = '0;
      run_model(sm, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
